// File: rtl/dbg_pkg.sv
// Shared constants, FSM state type and snapshot layout for the EX/MEM debug reader.
// Define DBG_FRAME_CHECKSUM_EN to append an XOR checksum byte to every dump frame.
package dbg_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CMD_HALT = 8'h68;

  localparam logic [7:0] FRAME_HDR_DEF = 8'hA5;

`ifdef DBG_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP
  } state_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wr_data;
    logic [4:0]  addr_dest;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic        zero;
    logic [5:0]  opcode;
  } snap_t;

endpackage

// File: rtl/dbg_frame_shifter.sv
// Snapshot registers and byte sequencer for one EX/MEM dump frame.
// With DBG_FRAME_CHECKSUM_EN defined a trailing XOR byte of bytes 1..11 is emitted.
module dbg_frame_shifter
  import dbg_pkg::*;
#(
  parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  input  snap_t      snap_in,
  output logic [7:0] byte_out,
  output logic       last
);

  snap_t            snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign last = (idx_q == IDX_W'(FRAME_LEN - 1));

  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    if (load) begin
      snap_d = snap_in;
      idx_d  = '0;
    end else if (advance) begin
      idx_d = last ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
      idx_q  <= '0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
    end
  end

`ifdef DBG_FRAME_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = snap_q.alu[31:24] ^ snap_q.alu[23:16] ^ snap_q.alu[15:8] ^ snap_q.alu[7:0]
              ^ snap_q.wr_data[31:24] ^ snap_q.wr_data[23:16]
              ^ snap_q.wr_data[15:8] ^ snap_q.wr_data[7:0]
              ^ {3'b000, snap_q.addr_dest}
              ^ {snap_q.mem, snap_q.wb, snap_q.zero, 2'b00}
              ^ {2'b00, snap_q.opcode};
`endif

  // Byte order is MSB first within each multi-byte field.
  always_comb begin
    byte_out = 8'h00;
    case (idx_q)
      4'd0:  byte_out = FRAME_HDR;
      4'd1:  byte_out = snap_q.alu[31:24];
      4'd2:  byte_out = snap_q.alu[23:16];
      4'd3:  byte_out = snap_q.alu[15:8];
      4'd4:  byte_out = snap_q.alu[7:0];
      4'd5:  byte_out = snap_q.wr_data[31:24];
      4'd6:  byte_out = snap_q.wr_data[23:16];
      4'd7:  byte_out = snap_q.wr_data[15:8];
      4'd8:  byte_out = snap_q.wr_data[7:0];
      4'd9:  byte_out = {3'b000, snap_q.addr_dest};
      4'd10: byte_out = {snap_q.mem, snap_q.wb, snap_q.zero, 2'b00};
      4'd11: byte_out = {2'b00, snap_q.opcode};
`ifdef DBG_FRAME_CHECKSUM_EN
      4'd12: byte_out = csum;
`endif
      default: byte_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/dbg_exmem_reader.sv
// Debug command FSM: drives pipeline clock-enable for run/step and streams EX/MEM dumps.
// Frame length follows DBG_FRAME_CHECKSUM_EN (see dbg_pkg).
module dbg_exmem_reader
  import dbg_pkg::*;
#(
  parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  output logic        cmd_ready,
  input  logic        pc_end,
  input  logic [31:0] exmem_alu,
  input  logic [31:0] exmem_wr_data,
  input  logic [4:0]  exmem_addr_dest,
  input  logic [2:0]  exmem_mem,
  input  logic [1:0]  exmem_wb,
  input  logic        exmem_zero,
  input  logic [5:0]  exmem_opcode,
  output logic        db_ena,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic        busy
);

  // Handshakes: a transfer happens on the posedge where valid && ready are both high;
  // the sender holds its payload stable until then, and ready never depends on valid.

  state_e state_q, state_d;
  logic   db_ena_q, db_ena_d;
  logic   busy_q, busy_d;
  logic   tx_valid_q, tx_valid_d;
  logic   cmd_ready_q, cmd_ready_d;
  logic   load, advance, last;
  logic [7:0] shift_byte;
  snap_t  snap_in;

  assign snap_in = {exmem_alu, exmem_wr_data, exmem_addr_dest,
                    exmem_mem, exmem_wb, exmem_zero, exmem_opcode};

  dbg_frame_shifter #(.FRAME_HDR(FRAME_HDR)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (advance),
    .snap_in  (snap_in),
    .byte_out (shift_byte),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_byte == CMD_RUN) begin
            state_d = ST_RUN;
          end else if (cmd_byte == CMD_STEP) begin
            state_d = ST_STEP;
          end else if (cmd_byte == CMD_DUMP) begin
            load    = 1'b1;
            state_d = ST_DUMP;
          end
        end
      end
      ST_RUN: begin
        if (pc_end || (cmd_valid && cmd_byte == CMD_HALT)) state_d = ST_IDLE;
      end
      ST_STEP: state_d = ST_IDLE;
      ST_DUMP: begin
        if (tx_ready) begin
          advance = 1'b1;
          if (last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so nothing reaches a port combinationally.
    db_ena_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    busy_d      = (state_d != ST_IDLE);
    tx_valid_d  = (state_d == ST_DUMP);
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      db_ena_q    <= 1'b0;
      busy_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      db_ena_q    <= db_ena_d;
      busy_q      <= busy_d;
      tx_valid_q  <= tx_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign db_ena    = db_ena_q;
  assign busy      = busy_q;
  assign tx_valid  = tx_valid_q;
  assign cmd_ready = cmd_ready_q;
  assign tx_byte   = tx_valid_q ? shift_byte : 8'h00;

endmodule

// File: tb/tb_dbg_exmem_reader.sv
// Directed + randomized bench for dbg_exmem_reader with a byte-list frame model.
// Honours DBG_FRAME_CHECKSUM_EN for the expected frame length and trailing byte.
module tb_dbg_exmem_reader;

`ifdef DBG_FRAME_CHECKSUM_EN
  localparam int N_FRAME = 13;
`else
  localparam int N_FRAME = 12;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        cmd_ready;
  logic        pc_end;
  logic [31:0] exmem_alu;
  logic [31:0] exmem_wr_data;
  logic [4:0]  exmem_addr_dest;
  logic [2:0]  exmem_mem;
  logic [1:0]  exmem_wb;
  logic        exmem_zero;
  logic [5:0]  exmem_opcode;
  logic        db_ena;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        busy;

  dbg_exmem_reader dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_byte        (cmd_byte),
    .cmd_ready       (cmd_ready),
    .pc_end          (pc_end),
    .exmem_alu       (exmem_alu),
    .exmem_wr_data   (exmem_wr_data),
    .exmem_addr_dest (exmem_addr_dest),
    .exmem_mem       (exmem_mem),
    .exmem_wb        (exmem_wb),
    .exmem_zero      (exmem_zero),
    .exmem_opcode    (exmem_opcode),
    .db_ena          (db_ena),
    .tx_valid        (tx_valid),
    .tx_byte         (tx_byte),
    .tx_ready        (tx_ready),
    .busy            (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference frame as a plain byte list built from field values.
  task automatic build_frame(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest,
                             input logic [2:0] mem, input logic [1:0] wb, input logic zero,
                             input logic [5:0] opc);
    logic [7:0] x;
    exp_q = {};
    exp_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((alu >> (8 * i)) & 32'hFF));
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((wd >> (8 * i)) & 32'hFF));
    exp_q.push_back(8'(dest));
    exp_q.push_back(8'(32'(mem) * 32 + 32'(wb) * 8 + 32'(zero) * 4));
    exp_q.push_back(8'(opc));
`ifdef DBG_FRAME_CHECKSUM_EN
    x = 8'h00;
    for (int i = 1; i <= 11; i++) x = x ^ exp_q[i];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic drive_snap(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest,
                            input logic [2:0] mem, input logic [1:0] wb, input logic zero,
                            input logic [5:0] opc);
    exmem_alu = alu; exmem_wr_data = wd; exmem_addr_dest = dest;
    exmem_mem = mem; exmem_wb = wb; exmem_zero = zero; exmem_opcode = opc;
  endtask

  task automatic scramble_live();
    drive_snap($urandom, $urandom, 5'($urandom), 3'($urandom), 2'($urandom),
               1'($urandom), 6'($urandom));
  endtask

  // Driver: present one command from a negedge, returns 1ns after the accepting edge.
  task automatic send_cmd(input logic [7:0] c);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_byte  = c;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_byte  = 8'($urandom);
  endtask

  // Count db_ena-high cycles; pc_end raised / 'h' presented at the given negedge index.
  task automatic measure_ena(input int pc_at, input int h_at, input bit noise, output int cnt);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (db_ena) cnt++;
      if (i == pc_at) pc_end = 1'b1;
      cmd_valid = 1'b0;
      if (i == h_at) begin
        cmd_valid = 1'b1;
        cmd_byte  = 8'h68;
      end else if (noise && i == 0) begin
        cmd_valid = 1'b1;
        cmd_byte  = 8'h21;
      end
    end
    pc_end    = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Receiver: collects n bytes against exp_q, checks hold-under-backpressure.
  task automatic recv_frame(input int n, input bit rnd, output int cycles);
    int         got;
    logic [7:0] held;
    bit         held_v;
    got = 0; held = 8'h00; held_v = 1'b0; cycles = 0;
    while (got < n && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (held_v) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_byte", {24'd0, tx_byte}, {24'd0, held});
      end
      scramble_live();
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held_v = 1'b0;
      if (tx_valid) begin
        if (tx_ready) begin
          check($sformatf("frame_byte%0d", got), {24'd0, tx_byte}, {24'd0, exp_q[got]});
          got++;
        end else begin
          held   = tx_byte;
          held_v = 1'b1;
        end
      end
    end
    check("frame_complete", 32'(got), 32'(n));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_db_ena"},    {31'd0, db_ena},    32'd0);
    check({tag, "_tx_valid"},  {31'd0, tx_valid},  32'd0);
    check({tag, "_tx_byte"},   {24'd0, tx_byte},   32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int cnt, cyc, k;
    reset = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; pc_end = 1'b0; tx_ready = 1'b0;
    drive_snap(32'h0, 32'h0, 5'h0, 3'h0, 2'h0, 1'b0, 6'h0);

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // Unknown code in IDLE is swallowed
    send_cmd(8'h00);
    @(negedge clk);
    check_idle("unknown");

    // Single step: exactly one enable cycle
    send_cmd(8'h73);
    measure_ena(-1, -1, 1'b1, cnt);
    check("step_ena_cycles", 32'(cnt), 32'd1);
    check_idle("after_step");

    // Free run ended by pc_end raised after 7 cycles
    send_cmd(8'h63);
    measure_ena(7, -1, 1'b1, cnt);
    check("run_pc_end7", 32'(cnt), 32'd8);
    check_idle("after_run");

    // pc_end already high at acceptance still gives one cycle
    pc_end = 1'b1;
    send_cmd(8'h63);
    measure_ena(-1, -1, 1'b0, cnt);
    check("run_pc_end_at_accept", 32'(cnt), 32'd1);

    // Halt command accepted on the 3rd edge after entering RUN
    send_cmd(8'h63);
    measure_ena(-1, 2, 1'b1, cnt);
    check("run_halt3", 32'(cnt), 32'd3);

    // Random run terminations: whichever of pc_end / halt lands first wins
    for (int r = 0; r < 4; r++) begin
      int pa, ha, e;
      pa = int'($urandom_range(0, 10));
      ha = int'($urandom_range(1, 10));
      e  = (pa < ha) ? pa + 1 : ha + 1;
      send_cmd(8'h63);
      measure_ena(pa, ha, 1'b0, cnt);
      check($sformatf("run_rand%0d", r), 32'(cnt), 32'(e));
    end
    check_idle("after_runs");

    // Reset in the middle of a run
    send_cmd(8'h63);
    @(negedge clk);
    check("mid_run_ena", {31'd0, db_ena}, 32'd1);
    reset = 1'b1;
    #1;
    check_idle("reset_mid_run");
    @(negedge clk);
    reset = 1'b0;

    // Directed dump with random backpressure; live inputs scrambled after capture
    drive_snap(32'h1234_5678, 32'hCAFE_F00D, 5'd9, 3'b010, 2'b01, 1'b1, 6'h2B);
    build_frame(32'h1234_5678, 32'hCAFE_F00D, 5'd9, 3'b010, 2'b01, 1'b1, 6'h2B);
    send_cmd(8'h64);
    check("dump_busy", {31'd0, busy}, 32'd1);
    check("dump_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    recv_frame(N_FRAME, 1'b1, cyc);
    @(negedge clk);
    check_idle("after_dump");

    // Tied-high ready: one byte per cycle, frame spans N_FRAME cycles
    drive_snap(32'h1234_5678, 32'hCAFE_F00D, 5'd9, 3'b010, 2'b01, 1'b1, 6'h2B);
    send_cmd(8'h64);
    recv_frame(N_FRAME, 1'b0, cyc);
    check("dump_cycles", 32'(cyc), 32'(N_FRAME));
    @(negedge clk);
    tx_ready = 1'b0;
    check_idle("after_fast_dump");

    // Random snapshots
    for (int r = 0; r < 3; r++) begin
      logic [31:0] a, w;
      logic [4:0] d; logic [2:0] m; logic [1:0] b; logic z; logic [5:0] o;
      a = $urandom; w = $urandom; d = 5'($urandom); m = 3'($urandom);
      b = 2'($urandom); z = 1'($urandom); o = 6'($urandom);
      drive_snap(a, w, d, m, b, z, o);
      build_frame(a, w, d, m, b, z, o);
      send_cmd(8'h64);
      recv_frame(N_FRAME, 1'b1, cyc);
    end

    // Reset with byte 5 pending, then a fresh dump restarts at the header
    k = 5;
    drive_snap(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd17, 3'b101, 2'b10, 1'b0, 6'h3F);
    build_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd17, 3'b101, 2'b10, 1'b0, 6'h3F);
    send_cmd(8'h64);
    recv_frame(k, 1'b0, cyc);
    @(negedge clk);
    tx_ready = 1'b0;
    check("byte5_pending_valid", {31'd0, tx_valid}, 32'd1);
    check("byte5_pending_value", {24'd0, tx_byte}, {24'd0, exp_q[k]});
    reset = 1'b1;
    #1;
    check_idle("reset_mid_dump");
    @(negedge clk);
    reset = 1'b0;
    drive_snap(32'h1234_5678, 32'hCAFE_F00D, 5'd9, 3'b010, 2'b01, 1'b1, 6'h2B);
    build_frame(32'h1234_5678, 32'hCAFE_F00D, 5'd9, 3'b010, 2'b01, 1'b1, 6'h2B);
    send_cmd(8'h64);
    recv_frame(N_FRAME, 1'b1, cyc);
    @(negedge clk);
    tx_ready = 1'b0;
    check_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
